mem_wb_stage: RTL and testbench

MEM/WB pipeline register and writeback logic, sitting directly upstream of the register file write port. Captures the retiring instruction from the MEM stage and extracts load data from the synchronous data-memory read word, which arrives in the WB cycle. Selects the writeback source and drives the regfile write port (rd, write_data, wr_en). Maintains a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback logic.
//
// Captures the instruction retiring from MEM, formats load data from the synchronous
// data-memory read word (which arrives in the WB cycle), selects the writeback source and
// drives the register-file write port. Also keeps a retired-instruction counter.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall_i             hold the WB register; the WB instruction does not retire this cycle
//   flush_i             squash the instruction entering WB (overrides stall_i)
//   mem_*_i             fields of the instruction currently in MEM
//   dmem_rdata_i        aligned data-memory word, valid in the WB cycle
//   wb_rd_o             regfile destination index
//   wb_write_data_o     regfile write data (also a forwarding source)
//   wb_wr_en_o          regfile write enable, only in the retiring cycle and never for x0
//   wb_valid_o          WB holds a valid instruction
//   retire_o            one pulse per retired instruction
//   instret_o           retired-instruction count, wraps
module mem_wb_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned INSTRET_WIDTH  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      mem_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
  input  logic                      mem_reg_write_i,
  input  logic [1:0]                mem_wb_sel_i,
  input  logic [2:0]                mem_funct3_i,
  input  logic [1:0]                mem_addr_lo_i,
  input  logic [XLEN-1:0]           mem_alu_result_i,
  input  logic [XLEN-1:0]           mem_pc_plus4_i,
  input  logic [XLEN-1:0]           dmem_rdata_i,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
  output logic [XLEN-1:0]           wb_write_data_o,
  output logic                      wb_wr_en_o,
  output logic                      wb_valid_o,
  output logic                      retire_o,
  output logic [INSTRET_WIDTH-1:0]  instret_o
);

  localparam logic [1:0] WbSelLoad = 2'b01;
  localparam logic [1:0] WbSelPc4  = 2'b10;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  localparam logic [INSTRET_WIDTH-1:0] InstretOne = {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

  logic                      valid_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      reg_write_q;
  logic [1:0]                wb_sel_q;
  logic [2:0]                funct3_q;
  logic [1:0]                addr_lo_q;
  logic [XLEN-1:0]           alu_result_q;
  logic [XLEN-1:0]           pc_plus4_q;
  logic [INSTRET_WIDTH-1:0]  instret_q, instret_d;

  logic            retire;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] write_data;

  // Priority: reset > flush > stall > advance. On flush only valid matters; the
  // remaining fields simply hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      wb_sel_q     <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      alu_result_q <= '0;
      pc_plus4_q   <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q      <= mem_valid_i;
      rd_q         <= mem_rd_i;
      reg_write_q  <= mem_reg_write_i;
      wb_sel_q     <= mem_wb_sel_i;
      funct3_q     <= mem_funct3_i;
      addr_lo_q    <= mem_addr_lo_i;
      alu_result_q <= mem_alu_result_i;
      pc_plus4_q   <= mem_pc_plus4_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  // A stalled instruction neither retires nor writes; it does so once, in the first
  // unstalled cycle.
  assign retire = valid_q & ~stall_i;

  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + InstretOne;
    end
  end

  // Load extraction from the raw word. Misaligned accesses never reach here, so
  // addr_lo[0] is irrelevant for halfwords.
  always_comb begin
    load_byte = 8'h00;
    unique case (addr_lo_q)
      2'd0: load_byte = dmem_rdata_i[7:0];
      2'd1: load_byte = dmem_rdata_i[15:8];
      2'd2: load_byte = dmem_rdata_i[23:16];
      2'd3: load_byte = dmem_rdata_i[31:24];
    endcase

    load_half = addr_lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    load_data = '0;
    case (funct3_q)
      F3Lb:    load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3Lbu:   load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3Lh:    load_data = {{(XLEN-16){load_half[15]}}, load_half};
      F3Lhu:   load_data = {{(XLEN-16){1'b0}}, load_half};
      F3Lw:    load_data = dmem_rdata_i;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    write_data = alu_result_q;
    unique case (wb_sel_q)
      WbSelLoad: write_data = load_data;
      WbSelPc4:  write_data = pc_plus4_q;
      default:   write_data = alu_result_q;
    endcase
  end

  assign wb_rd_o         = rd_q;
  assign wb_write_data_o = write_data;
  assign wb_wr_en_o      = retire & reg_write_q & (rd_q != '0);
  assign wb_valid_o      = valid_q;
  assign retire_o        = retire;
  assign instret_o       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage. Expected writebacks are queued when an
// instruction is driven into MEM and compared while it sits in WB. A second instance
// with a 4-bit counter shares all inputs to exercise counter wrap.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i;
  logic        mem_valid_i;
  logic [4:0]  mem_rd_i;
  logic        mem_reg_write_i;
  logic [1:0]  mem_wb_sel_i;
  logic [2:0]  mem_funct3_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] mem_alu_result_i, mem_pc_plus4_i, dmem_rdata_i;

  logic [4:0]  wb_rd_o;
  logic [31:0] wb_write_data_o;
  logic        wb_wr_en_o, wb_valid_o, retire_o;
  logic [63:0] instret_o;

  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        w_wr_en, w_valid, w_retire;
  logic [3:0]  w_instret;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .mem_valid_i      (mem_valid_i),
    .mem_rd_i         (mem_rd_i),
    .mem_reg_write_i  (mem_reg_write_i),
    .mem_wb_sel_i     (mem_wb_sel_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_addr_lo_i    (mem_addr_lo_i),
    .mem_alu_result_i (mem_alu_result_i),
    .mem_pc_plus4_i   (mem_pc_plus4_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .wb_rd_o          (wb_rd_o),
    .wb_write_data_o  (wb_write_data_o),
    .wb_wr_en_o       (wb_wr_en_o),
    .wb_valid_o       (wb_valid_o),
    .retire_o         (retire_o),
    .instret_o        (instret_o)
  );

  mem_wb_stage #(.INSTRET_WIDTH(4)) dut_w (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .mem_valid_i      (mem_valid_i),
    .mem_rd_i         (mem_rd_i),
    .mem_reg_write_i  (mem_reg_write_i),
    .mem_wb_sel_i     (mem_wb_sel_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_addr_lo_i    (mem_addr_lo_i),
    .mem_alu_result_i (mem_alu_result_i),
    .mem_pc_plus4_i   (mem_pc_plus4_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .wb_rd_o          (w_rd),
    .wb_write_data_o  (w_data),
    .wb_wr_en_o       (w_wr_en),
    .wb_valid_o       (w_valid),
    .retire_o         (w_retire),
    .instret_o        (w_instret)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wr_en;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_retired = 0;
  logic        mon_en = 1'b0;
  logic [31:0] prev_dmem = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference load formatting, written as shifts rather than lane selects.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * lo);
    h = w >> (16 * lo[1]);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'h0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'h0, h[15:0]};
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle scoreboard check of whatever sits in WB.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("instret", instret_o, 64'(n_retired));
      check_eq("instret_w", {60'h0, w_instret}, {60'h0, 4'(n_retired)});
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", {63'h0, wb_valid_o}, 64'h0);
        end else begin
          check_eq("wb_rd", {59'h0, wb_rd_o}, {59'h0, exp_q[0].rd});
          check_eq("wb_data", {32'h0, wb_write_data_o}, {32'h0, exp_q[0].data});
          check_eq("retire", {63'h0, retire_o}, {63'h0, !stall_i});
          check_eq("wr_en", {63'h0, wb_wr_en_o}, {63'h0, !stall_i && exp_q[0].wr_en});
          check_eq("wr_en_w", {63'h0, w_wr_en}, {63'h0, !stall_i && exp_q[0].wr_en});
          if (!stall_i) begin
            void'(exp_q.pop_front());
            n_retired++;
          end
        end
      end else begin
        check_eq("idle_retire", {63'h0, retire_o}, 64'h0);
        check_eq("idle_wr_en", {63'h0, wb_wr_en_o}, 64'h0);
        check_eq("idle_retire_w", {63'h0, w_retire}, 64'h0);
      end
    end
  end

  task automatic garbage_mem();
    mem_valid_i      = 1'b1;
    mem_rd_i         = 5'($urandom_range(1, 31));
    mem_reg_write_i  = 1'b1;
    mem_wb_sel_i     = 2'($urandom);
    mem_funct3_i     = 3'($urandom);
    mem_addr_lo_i    = 2'($urandom);
    mem_alu_result_i = $urandom;
    mem_pc_plus4_i   = $urandom;
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    garbage_mem();
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("rst_valid", {63'h0, wb_valid_o}, 64'h0);
    check_eq("rst_wr_en", {63'h0, wb_wr_en_o}, 64'h0);
    check_eq("rst_retire", {63'h0, retire_o}, 64'h0);
    check_eq("rst_rd", {59'h0, wb_rd_o}, 64'h0);
    check_eq("rst_data", {32'h0, wb_write_data_o}, 64'h0);
    check_eq("rst_instret", instret_o, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_valid_i = 1'b0; dmem_rdata_i = '0;
    prev_dmem = '0;
    exp_q.delete();
    n_retired = 0;
    mon_en = 1'b1;
  endtask

  // Drive one instruction into MEM; dm is the word memory returns in its WB cycle.
  task automatic send(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                      input logic [31:0] pc4, input logic [31:0] dm);
    exp_t e;
    @(posedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b0;
    dmem_rdata_i = prev_dmem;
    prev_dmem = dm;
    mem_valid_i = 1'b1; mem_rd_i = rd; mem_reg_write_i = rw; mem_wb_sel_i = sel;
    mem_funct3_i = f3; mem_addr_lo_i = lo; mem_alu_result_i = alu; mem_pc_plus4_i = pc4;
    e.rd    = rd;
    e.wr_en = rw && (rd != 5'd0);
    e.data  = (sel == 2'b01) ? model_load(f3, lo, dm) : (sel == 2'b10) ? pc4 : alu;
    exp_q.push_back(e);
  endtask

  task automatic bubble();
    @(posedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b0;
    dmem_rdata_i = prev_dmem;
    prev_dmem = '0;
    mem_valid_i = 1'b0;
  endtask

  // Stalled cycles present junk at MEM; none of it may be captured.
  task automatic stall_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      stall_i = 1'b1; flush_i = 1'b0;
      dmem_rdata_i = prev_dmem;
      garbage_mem();
    end
  endtask

  // Flush while the WB instruction keeps retiring; the entering junk is squashed.
  task automatic squash();
    @(posedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b1;
    dmem_rdata_i = prev_dmem;
    prev_dmem = '0;
    garbage_mem();
  endtask

  // Stall and flush together: the stalled WB instruction is discarded unretired.
  task automatic stall_flush();
    @(posedge clk); #1;
    stall_i = 1'b1; flush_i = 1'b1;
    dmem_rdata_i = prev_dmem;
    garbage_mem();
    @(posedge clk); #1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    stall_i = 1'b0; flush_i = 1'b0; mem_valid_i = 1'b0;
    dmem_rdata_i = '0; prev_dmem = '0;
    @(negedge clk);
    check_eq("stall_flush_valid", {63'h0, wb_valid_o}, 64'h0);
  endtask

  localparam logic [31:0] LdWord = 32'h80F1_7F82;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; dmem_rdata_i = '0;
    mem_valid_i = 1'b0; mem_rd_i = '0; mem_reg_write_i = 1'b0; mem_wb_sel_i = '0;
    mem_funct3_i = '0; mem_addr_lo_i = '0; mem_alu_result_i = '0; mem_pc_plus4_i = '0;

    reset_dut();

    // ALU writeback
    send(5'd5, 1'b1, 2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
    bubble();

    // Loads, back to back
    send(5'd6,  1'b1, 2'b01, 3'b000, 2'd0, 32'h100, 32'h0, LdWord);
    send(5'd7,  1'b1, 2'b01, 3'b100, 2'd0, 32'h100, 32'h0, LdWord);
    send(5'd8,  1'b1, 2'b01, 3'b000, 2'd1, 32'h101, 32'h0, LdWord);
    send(5'd9,  1'b1, 2'b01, 3'b001, 2'd2, 32'h102, 32'h0, LdWord);
    send(5'd10, 1'b1, 2'b01, 3'b101, 2'd2, 32'h102, 32'h0, LdWord);
    send(5'd11, 1'b1, 2'b01, 3'b010, 2'd0, 32'h100, 32'h0, LdWord);
    send(5'd12, 1'b1, 2'b01, 3'b011, 2'd0, 32'h100, 32'h0, LdWord);
    send(5'd13, 1'b1, 2'b01, 3'b000, 2'd3, 32'h103, 32'h0, LdWord);
    bubble();

    // JAL link, x0 destination, sel 11, no reg_write
    send(5'd1,  1'b1, 2'b10, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0);
    send(5'd0,  1'b1, 2'b10, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0000_0104, 32'h0);
    send(5'd14, 1'b1, 2'b11, 3'b000, 2'd0, 32'hCAFE_0011, 32'h0000_0200, 32'h0);
    send(5'd15, 1'b0, 2'b00, 3'b000, 2'd0, 32'h0000_5555, 32'h0, 32'h0);
    bubble();

    // Stall a load in WB for three cycles, then let it retire once
    send(5'd20, 1'b1, 2'b01, 3'b001, 2'd2, 32'h0, 32'h0, LdWord);
    stall_cycles(3);
    bubble();
    bubble();

    // Stall together with flush discards the WB instruction
    send(5'd21, 1'b1, 2'b00, 3'b000, 2'd0, 32'h7777_0000, 32'h0, 32'h0);
    stall_flush();
    bubble();

    // Plain flush squashes the incoming instruction only
    send(5'd22, 1'b1, 2'b00, 3'b000, 2'd0, 32'h2222_2222, 32'h0, 32'h0);
    squash();
    bubble();
    bubble();

    // Random mix of instructions, stalls and bubbles
    for (int i = 0; i < 60; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        send(5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
             $urandom, $urandom, $urandom);
      end else if (r < 8) begin
        stall_cycles(int'($urandom_range(1, 2)));
      end else begin
        bubble();
      end
    end
    bubble();
    bubble();

    // Reset while a stalled instruction sits in WB
    send(5'd3, 1'b1, 2'b00, 3'b000, 2'd0, 32'h3333_3333, 32'h0, 32'h0);
    stall_cycles(2);
    reset_dut();

    // Counter wrap on the 4-bit instance: 17 retirements leave 1
    for (int i = 0; i < 17; i++) begin
      send(5'(i + 1), 1'b1, 2'b00, 3'b000, 2'd0, 32'(i * 3), 32'h0, 32'h0);
    end
    bubble();
    bubble();
    @(negedge clk);
    check_eq("wrap_w", {60'h0, w_instret}, 64'd1);
    check_eq("wrap_64", instret_o, 64'd17);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
